leaf_out_arbiter: RTL and testbench

LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

---
 rtl/leaf_pkg.sv | 33 +++
 rtl/leaf_out_arbiter_rr_arbiter.sv | 33 +++
 rtl/leaf_out_arbiter.sv | 170 +++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// Purpose: shared field widths, packet bit positions and output FSM encoding for the leaf egress arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package leaf_pkg;

    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;
    localparam int PAYLOAD_W = 32;
    localparam int CRD_AMT_W = 7;

    // One valid flag plus the routing header plus the user word.
    localparam int PKT_W = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;

    // Packet field positions, LSB upward: payload, seq, dst_port, dst_leaf, valid flag.
    localparam int PAYLOAD_LSB  = 0;
    localparam int SEQ_LSB      = PAYLOAD_LSB + PAYLOAD_W;
    localparam int DST_PORT_LSB = SEQ_LSB + ADDR_W;
    localparam int DST_LEAF_LSB = DST_PORT_LSB + PORT_W;
    localparam int VALID_BIT    = DST_LEAF_LSB + LEAF_W;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Width of an index into n items, never zero.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Purpose: round-robin pick of one requester, search starting just after ptr.
// Latency: combinational.
// Backpressure: none; caller gates req when it cannot accept a grant.
module rr_arbiter #(
    parameter int N        = 2,
    parameter int PTR_BITS = 1
) (
    input  logic [N-1:0]        req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [N-1:0]        grant
);

    logic                found;
    int                  idx;
    logic [PTR_BITS-1:0] sel;

    // Walk ports ptr+1 .. ptr+N (mod N) and grant the first one requesting.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            sel = PTR_BITS'(idx);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Purpose: round-robin merge of user word streams into one routed, sequenced, credit-limited egress.
// Latency: 1 cycle from ack_user pulse to pkt_vld.
// Backpressure: pkt_rdy low holds pkt_out/pkt_vld and withholds grants; zero credit blocks only that port.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 2,
    parameter int PAYLOAD_BITS  = PAYLOAD_W,
    parameter int NUM_LEAF_BITS = LEAF_W,
    parameter int NUM_PORT_BITS = PORT_W,
    parameter int NUM_ADDR_BITS = ADDR_W,
    parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int CREDIT_INIT   = 64,
    localparam int PIDX         = idx_bits(NUM_OUT_PORTS)
) (
    input  logic                                    clk_user,
    input  logic                                    reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user,
    output logic [NUM_OUT_PORTS-1:0]                ack_user,
    input  logic                                    cfg_we,
    input  logic [PIDX-1:0]                         cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dst_port,
    input  logic                                    crd_vld,
    input  logic [PIDX-1:0]                         crd_port,
    input  logic [CRD_AMT_W-1:0]                    crd_amt,
    output logic [PACKET_BITS-1:0]                  pkt_out,
    output logic                                    pkt_vld,
    input  logic                                    pkt_rdy
);

    localparam int CRD_W = $clog2(CREDIT_INIT + 1);
    localparam int SUM_W = ((CRD_W > CRD_AMT_W) ? CRD_W : CRD_AMT_W) + 1;

    out_state_t                 state_q;
    out_state_t                 state_d;
    logic [PIDX-1:0]            rr_ptr;
    logic [NUM_ADDR_BITS-1:0]   seq        [NUM_OUT_PORTS];
    logic [CRD_W-1:0]           credit     [NUM_OUT_PORTS];
    logic [CRD_W-1:0]           credit_d   [NUM_OUT_PORTS];
    logic [SUM_W-1:0]           credit_sum [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0]   route_leaf [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0]   route_port [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0]   route_ok;

    logic [NUM_OUT_PORTS-1:0]   eligible;
    logic [NUM_OUT_PORTS-1:0]   req;
    logic [NUM_OUT_PORTS-1:0]   grant;
    logic                       any_grant;
    logic                       slot_free;
    logic [PIDX-1:0]            gnt_idx;
    logic [PAYLOAD_BITS-1:0]    gnt_payload;

    // A port may compete only with a word, a credit and a configured route.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_OUT_PORTS; p++) begin
            eligible[p] = vld_user[p] && (credit[p] != '0) && route_ok[p];
        end
    end

    // The output register can take a packet when empty or when it drains this cycle.
    assign slot_free = (state_q == ST_EMPTY) || pkt_rdy;
    assign req       = slot_free ? eligible : '0;

    rr_arbiter #(
        .N        (NUM_OUT_PORTS),
        .PTR_BITS (PIDX)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign any_grant = |grant;
    assign ack_user  = grant;
    assign pkt_vld   = (state_q == ST_FULL);

    // Encode the one-hot grant and pick the granted user word.
    always_comb begin
        gnt_idx     = '0;
        gnt_payload = '0;
        for (int p = 0; p < NUM_OUT_PORTS; p++) begin
            if (grant[p]) begin
                gnt_idx     = PIDX'(p);
                gnt_payload = din_user[p*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Output FSM next state: fill on grant, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_grant) state_d = ST_FULL;
            ST_FULL:  if (pkt_rdy && !any_grant) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // Register the granted packet; held untouched while stalled since no grant happens then.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            pkt_out <= '0;
        end else if (any_grant) begin
            pkt_out <= {1'b1, route_leaf[gnt_idx], route_port[gnt_idx], seq[gnt_idx], gnt_payload};
        end
    end

    // Remember the last winner so the next search starts after it.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n)       rr_ptr <= PIDX'(NUM_OUT_PORTS - 1);
        else if (any_grant) rr_ptr <= gnt_idx;
    end

    // Per-port sequence number advances on each grant and wraps naturally.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_OUT_PORTS; p++) seq[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_OUT_PORTS; p++) begin
                if (grant[p]) seq[p] <= seq[p] + 1'b1;
            end
        end
    end

    // Credit update: spend one per grant, add returns, clamp at the initial ceiling.
    always_comb begin
        for (int p = 0; p < NUM_OUT_PORTS; p++) begin
            credit_sum[p] = SUM_W'(credit[p]) - SUM_W'(grant[p]);
            if (crd_vld && (crd_port == PIDX'(p))) begin
                credit_sum[p] = credit_sum[p] + SUM_W'(crd_amt);
            end
            if (credit_sum[p] > SUM_W'(CREDIT_INIT)) credit_d[p] = CRD_W'(CREDIT_INIT);
            else                                     credit_d[p] = credit_sum[p][CRD_W-1:0];
        end
    end

    // Credit registers.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_OUT_PORTS; p++) credit[p] <= CRD_W'(CREDIT_INIT);
        end else begin
            for (int p = 0; p < NUM_OUT_PORTS; p++) credit[p] <= credit_d[p];
        end
    end

    // Route table; a write alongside a grant of that port is seen by the following grant.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            route_ok <= '0;
            for (int p = 0; p < NUM_OUT_PORTS; p++) begin
                route_leaf[p] <= '0;
                route_port[p] <= '0;
            end
        end else if (cfg_we) begin
            route_leaf[cfg_port] <= cfg_dst_leaf;
            route_port[cfg_port] <= cfg_dst_port;
            route_ok[cfg_port]   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Purpose: directed self-checking bench for leaf_out_arbiter.
// Latency: checks ack-to-pkt_vld of one cycle and back-to-back issue.
// Backpressure: exercises pkt_rdy stalls, credit exhaustion and reset during a stall.
module tb_leaf_out_arbiter;
    import leaf_pkg::*;

    logic          clk_user = 1'b0;
    logic          reset_n;
    logic [63:0]   din_user;
    logic [1:0]    vld_user;
    logic [1:0]    ack_user;
    logic          cfg_we;
    logic [0:0]    cfg_port;
    logic [4:0]    cfg_dst_leaf;
    logic [3:0]    cfg_dst_port;
    logic          crd_vld;
    logic [0:0]    crd_port;
    logic [6:0]    crd_amt;
    logic [48:0]   pkt_out;
    logic          pkt_vld;
    logic          pkt_rdy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_seq [2];
    int cnt;
    logic [48:0] exp_pkt;
    logic [6:0]  seq_obs [130];

    always #5 clk_user = ~clk_user;

    leaf_out_arbiter dut (
        .clk_user     (clk_user),
        .reset_n      (reset_n),
        .din_user     (din_user),
        .vld_user     (vld_user),
        .ack_user     (ack_user),
        .cfg_we       (cfg_we),
        .cfg_port     (cfg_port),
        .cfg_dst_leaf (cfg_dst_leaf),
        .cfg_dst_port (cfg_dst_port),
        .crd_vld      (crd_vld),
        .crd_port     (crd_port),
        .crd_amt      (crd_amt),
        .pkt_out      (pkt_out),
        .pkt_vld      (pkt_vld),
        .pkt_rdy      (pkt_rdy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    // Port 0 routes to leaf 3 / port 2, port 1 to leaf 5 / port 9.
    function automatic logic [48:0] mkpkt(input int p, input int s, input logic [31:0] d);
        logic [6:0] s7;
        s7 = 7'(s);
        if (p == 0) return {1'b1, 5'd3, 4'd2, s7, d};
        else        return {1'b1, 5'd5, 4'd9, s7, d};
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        vld_user = 2'b00;
        cfg_we   = 1'b0;
        crd_vld  = 1'b0;
        pkt_rdy  = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        exp_seq[0] = 0;
        exp_seq[1] = 0;
    endtask

    task automatic cfg_routes();
        cfg_we = 1'b1; cfg_port = 1'b0; cfg_dst_leaf = 5'd3; cfg_dst_port = 4'd2;
        tick();
        cfg_port = 1'b1; cfg_dst_leaf = 5'd5; cfg_dst_port = 4'd9;
        tick();
        cfg_we = 1'b0;
    endtask

    // Count ack pulses on one port over a fixed number of cycles.
    task automatic count_grants(input int p, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk_user);
            if (ack_user[p]) n++;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0; din_user = '0; vld_user = 2'b11; cfg_we = 1'b0; cfg_port = '0;
        cfg_dst_leaf = '0; cfg_dst_port = '0; crd_vld = 1'b0; crd_port = '0; crd_amt = '0;
        pkt_rdy = 1'b1;
        exp_seq[0] = 0; exp_seq[1] = 0;

        // Reset state, with words offered but no routes.
        @(negedge clk_user);
        check_eq("rst_pkt_vld", 64'(pkt_vld), 64'd0);
        check_eq("rst_pkt_out", 64'(pkt_out), 64'd0);
        check_eq("rst_ack", 64'(ack_user), 64'd0);
        do_reset();
        cfg_routes();

        // Single word on port 0.
        vld_user = 2'b01; din_user[31:0] = 32'hDEADBEEF;
        @(negedge clk_user);
        check_eq("t1_ack", 64'(ack_user), 64'd1);
        check_eq("t1_vld_before", 64'(pkt_vld), 64'd0);
        tick();
        vld_user = 2'b00;
        @(negedge clk_user);
        check_eq("t1_vld_after", 64'(pkt_vld), 64'd1);
        check_eq("t1_pkt", 64'(pkt_out), 64'h1_1900_DEAD_BEEF);
        check_eq("t1_ack_gone", 64'(ack_user), 64'd0);
        exp_seq[0] = 1;
        tick();
        @(negedge clk_user);
        check_eq("t1_drained", 64'(pkt_vld), 64'd0);
        tick();

        // Both ports streaming: alternate starting with port 1.
        vld_user = 2'b11; din_user = {32'hB1B1_0001, 32'hA0A0_0000};
        for (int k = 0; k < 4; k++) begin
            int ep;
            ep = (k % 2 == 0) ? 1 : 0;
            @(negedge clk_user);
            check_eq("t2_ack", 64'(ack_user), 64'(2'b01 << ep));
            if (k > 0) begin
                check_eq("t2_vld", 64'(pkt_vld), 64'd1);
                check_eq("t2_pkt", 64'(pkt_out), 64'(exp_pkt));
            end
            exp_pkt = mkpkt(ep, exp_seq[ep], din_user[ep*32 +: 32]);
            exp_seq[ep]++;
            tick();
        end
        vld_user = 2'b00;
        @(negedge clk_user);
        check_eq("t2_last_pkt", 64'(pkt_out), 64'(exp_pkt));
        tick();

        // Stall for five cycles, then release.
        vld_user = 2'b01; din_user[31:0] = 32'hCAFE0001; pkt_rdy = 1'b0;
        @(negedge clk_user);
        check_eq("t3_ack_first", 64'(ack_user), 64'd1);
        exp_pkt = mkpkt(0, exp_seq[0], 32'hCAFE0001);
        exp_seq[0]++;
        tick();
        din_user[31:0] = 32'hCAFE0002;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_user);
            check_eq("t3_stall_ack", 64'(ack_user), 64'd0);
            check_eq("t3_stall_vld", 64'(pkt_vld), 64'd1);
            check_eq("t3_stall_pkt", 64'(pkt_out), 64'(exp_pkt));
            tick();
        end
        pkt_rdy = 1'b1;
        @(negedge clk_user);
        check_eq("t3_release_ack", 64'(ack_user), 64'd1);
        exp_pkt = mkpkt(0, exp_seq[0], 32'hCAFE0002);
        tick();
        vld_user = 2'b00;
        @(negedge clk_user);
        check_eq("t3_resume_pkt", 64'(pkt_out), 64'(exp_pkt));
        check_eq("t3_resume_vld", 64'(pkt_vld), 64'd1);
        tick();

        // Credit exhaustion on port 1, port 0 unaffected, then a return of 10.
        do_reset();
        cfg_routes();
        vld_user = 2'b10;
        count_grants(1, 80, cnt);
        check_eq("t4_p1_grants", 64'(cnt), 64'd64);
        vld_user = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_user);
            check_eq("t4_p0_served", 64'(ack_user), 64'd1);
            tick();
        end
        vld_user = 2'b10; crd_vld = 1'b1; crd_port = 1'b1; crd_amt = 7'd10;
        @(negedge clk_user);
        check_eq("t4_blocked", 64'(ack_user), 64'd0);
        tick();
        crd_vld = 1'b0;
        count_grants(1, 30, cnt);
        check_eq("t4_refill_grants", 64'(cnt), 64'd10);

        // Port 0 streaming with a one-credit return every cycle; sequence wrap.
        do_reset();
        cfg_routes();
        vld_user = 2'b01; din_user[31:0] = 32'h0000_5EED;
        crd_vld = 1'b1; crd_port = 1'b0; crd_amt = 7'd1;
        cnt = 0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk_user);
            if (ack_user[0]) cnt++;
            if (i > 0) seq_obs[i-1] = pkt_out[SEQ_LSB +: ADDR_W];
            tick();
        end
        vld_user = 2'b00;
        @(negedge clk_user);
        seq_obs[129] = pkt_out[SEQ_LSB +: ADDR_W];
        tick();
        check_eq("t5_grants", 64'(cnt), 64'd130);
        check_eq("t5_seq_first", 64'(seq_obs[0]), 64'd0);
        check_eq("t5_seq_127", 64'(seq_obs[127]), 64'd127);
        check_eq("t5_seq_wrap", 64'(seq_obs[128]), 64'd0);
        check_eq("t5_seq_after", 64'(seq_obs[129]), 64'd1);
        crd_vld = 1'b0; vld_user = 2'b01;
        count_grants(0, 80, cnt);
        check_eq("t5_credit_kept", 64'(cnt), 64'd64);

        // Async reset while a packet is stalled.
        do_reset();
        cfg_routes();
        vld_user = 2'b10; din_user[63:32] = 32'h7777_0000; pkt_rdy = 1'b0;
        tick();
        vld_user = 2'b00;
        @(negedge clk_user);
        check_eq("t6_held_vld", 64'(pkt_vld), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t6_rst_vld", 64'(pkt_vld), 64'd0);
        check_eq("t6_rst_pkt", 64'(pkt_out), 64'd0);
        check_eq("t6_rst_ack", 64'(ack_user), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1; pkt_rdy = 1'b1; vld_user = 2'b10;
        @(negedge clk_user);
        check_eq("t6_no_route", 64'(ack_user), 64'd0);
        tick();
        vld_user = 2'b00;
        cfg_routes();
        vld_user = 2'b10;
        count_grants(1, 80, cnt);
        check_eq("t6_credit_reinit", 64'(cnt), 64'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
